mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2: cycles from mem_addr valid to mem_rdata sampled; legal 1..15.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port req, input, 2 bits: access request; bit 0 = instruction fetch, bit 1 = data.
REQ-005 SHALL have port addr0/addr1, input, 64 bits each: per-requester address.
REQ-006 SHALL have port wr, input, 2 bits: per-requester write enable (1 = write, 0 = read).
REQ-007 SHALL have port wdata0/wdata1, input, 64 bits each: per-requester write data.
REQ-008 SHALL have port gnt, output, 2 bits: one-hot, one-cycle grant pulse.
REQ-009 SHALL have port rvalid, output, 2 bits: one-hot, one-cycle completion pulse (read data valid or write done).
REQ-010 SHALL have port rdata, output, 64 bits: last captured read data, shared by both requesters.
REQ-011 SHALL have port mem_addr, output, 64 bits: registered memory address.
REQ-012 SHALL have port mem_wr, output, 1 bit: memory write strobe.
REQ-013 SHALL have port mem_wdata, output, 64 bits: registered memory write data.
REQ-014 SHALL have port mem_rdata, input, 64 bits: memory read data.

Function
REQ-015 SHALL implement FSM with states IDLE and WAIT plus a 4-bit down-counter cnt and a 1-bit owner register.
REQ-016 In IDLE with req != 0 at an edge, SHALL pick a winner, set gnt[winner]=1 for the following cycle, register addr/wdata/wr of winner into mem_addr/mem_wdata/mem_wr, set owner and cnt=MEM_LAT, and enter WAIT.
REQ-017 req SHALL be sampled only in IDLE; requests raised during WAIT wait; req dropped before grant is a withdrawal with no access.
REQ-018 mem_wr SHALL be high for exactly the first WAIT cycle, then 0; mem_addr/mem_wdata SHALL hold until the next grant.
REQ-019 In WAIT, cnt SHALL decrement each edge; at the edge where cnt goes 1->0, rdata SHALL capture mem_rdata (reads only; unchanged on writes), rvalid[owner] SHALL pulse for the next cycle, and FSM SHALL return to IDLE.
REQ-020 Latency: grant edge to rvalid-asserting edge = MEM_LAT edges; a new request may be sampled in the same IDLE cycle that rvalid is high, giving one access per MEM_LAT+1 cycles back-to-back.
REQ-021 Single requester SHALL always win; with both requesting, winner SHALL be the port not granted last (round-robin), and last-winner updates at every grant.
REQ-022 Requester SHALL hold req/addr/wr/wdata until it sees gnt and SHALL drop req in the gnt cycle; req still high after gnt is a new request.
REQ-023 gnt and rvalid SHALL never have more than one bit set, and never overlap in the same cycle for the same port.

Reset
REQ-024 rst low SHALL immediately force IDLE, cnt=0, gnt=0, rvalid=0, rdata=0, mem_addr=0, mem_wdata=0, mem_wr=0, last-winner=data (port 1) so port 0 wins the first tie.
REQ-025 Reset during WAIT SHALL abort the access with no rvalid; an in-flight mem_wr SHALL drop asynchronously.

Configuration
REQ-026 Macro MEM_ARB_FIXED_PRIO_EN defined: data port (1) SHALL always win ties and the last-winner register is removed; undefined: round-robin per REQ-021.

Structure
REQ-027 Package mem_arb_pkg SHALL hold the state enum (IDLE, WAIT), port index constants (PORT_INSTR=0, PORT_DATA=1) and counter width constant.
REQ-028 Winner selection SHALL be a sub-module mem_arb_rr_pick (inputs req, last; output winner index and valid).

Verification
REQ-029 MEM_LAT=2, req=01 read addr0=0x100, mem_rdata=0xDEAD -> gnt=01 next cycle, mem_addr=0x100, rvalid=01 with rdata=0xDEAD two edges after grant edge.
REQ-030 req=10 write addr1=0x40 wdata1=0x1234 -> mem_wr=1 for one cycle with mem_wdata=0x1234, rvalid=10, rdata unchanged.
REQ-031 req=11 held for four accesses after reset -> grants alternate 01,10,01,10 (with macro: 10,10,10,10).
REQ-032 req=11 arriving in the rvalid cycle of prior access -> new gnt on next cycle, no idle gap.
REQ-033 rst low in first WAIT cycle of a write -> mem_wr=0 immediately, no rvalid, next request served normally.
REQ-034 req=01 raised then dropped after one cycle during WAIT -> no grant to port 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam logic PORT_INSTR = 1'b0;
  localparam logic PORT_DATA  = 1'b1;
  localparam int   CNT_W      = 4;

  function automatic logic [1:0] port_onehot(input logic idx);
    return 2'b01 << idx;
  endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Two-requester winner selection: a lone requester wins, a tie goes to the port that did not win last.
module mem_arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner,
  output logic       valid
);

  assign valid  = |req;
  assign winner = (req == 2'b11) ? ~last : req[PORT_DATA];

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of a fixed-latency memory.
// Define MEM_ARB_FIXED_PRIO_EN to give the data port fixed priority on ties instead of round-robin.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [63:0] addr0,
  input  logic [63:0] addr1,
  input  logic [1:0]  wr,
  input  logic [63:0] wdata0,
  input  logic [63:0] wdata1,
  output logic [1:0]  gnt,
  output logic [1:0]  rvalid,
  output logic [63:0] rdata,
  output logic [63:0] mem_addr,
  output logic        mem_wr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic             acc_wr_q, acc_wr_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       rvalid_q, rvalid_d;
  logic [63:0]      rdata_q, rdata_d;
  logic [63:0]      mem_addr_q, mem_addr_d;
  logic [63:0]      mem_wdata_q, mem_wdata_d;
  logic             mem_wr_q, mem_wr_d;

  logic last;
  logic pick_winner;
  logic pick_valid;
  logic take;

  assign take = (state_q == IDLE) && pick_valid;

  mem_arb_rr_pick u_pick (
    .req    (req),
    .last   (last),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

`ifdef MEM_ARB_FIXED_PRIO_EN
  // Pretending the instruction port always won last makes every tie go to data.
  assign last = PORT_INSTR;
`else
  logic last_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      last_q <= PORT_DATA;
    else if (take) last_q <= pick_winner;
  end

  assign last = last_q;
`endif

  always_comb begin
    // NOTE: every _d gets a default before the case so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    acc_wr_d    = acc_wr_q;
    gnt_d       = 2'b00;
    rvalid_d    = 2'b00;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wr_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (take) begin
          state_d     = WAIT;
          cnt_d       = CNT_W'(MEM_LAT);
          owner_d     = pick_winner;
          acc_wr_d    = wr[pick_winner];
          gnt_d       = port_onehot(pick_winner);
          mem_addr_d  = pick_winner ? addr1 : addr0;
          mem_wdata_d = pick_winner ? wdata1 : wdata0;
          mem_wr_d    = wr[pick_winner];
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d  = IDLE;
          rvalid_d = port_onehot(owner_q);
          if (!acc_wr_q) rdata_d = mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_q     <= PORT_INSTR;
      acc_wr_q    <= 1'b0;
      gnt_q       <= 2'b00;
      rvalid_q    <= 2'b00;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wr_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      acc_wr_q    <= acc_wr_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wr_q    <= mem_wr_d;
    end
  end

  assign gnt       = gnt_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wr    = mem_wr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with MEM_LAT=2; tie expectations follow MEM_ARB_FIXED_PRIO_EN.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [63:0] addr0, addr1;
  logic [1:0]  wr;
  logic [63:0] wdata0, wdata1;
  logic [1:0]  gnt;
  logic [1:0]  rvalid;
  logic [63:0] rdata;
  logic [63:0] mem_addr;
  logic        mem_wr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  int n_vec = 0;
  int n_bad = 0;

  mem_arbiter #(.MEM_LAT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .addr0     (addr0),
    .addr1     (addr1),
    .wr        (wr),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] tie_exp [4];

  initial begin
`ifdef MEM_ARB_FIXED_PRIO_EN
    tie_exp = '{2'b10, 2'b10, 2'b10, 2'b10};
`else
    tie_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    rst = 1'b0; req = 2'b00; wr = 2'b00;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; mem_rdata = '0;
    step(); step();
    check("rst_gnt", gnt, 2'b00);
    check("rst_rvalid", rvalid, 2'b00);
    check("rst_rdata", rdata, 64'h0);
    check("rst_mem_addr", mem_addr, 64'h0);
    check("rst_mem_wr", mem_wr, 1'b0);
    check("rst_mem_wdata", mem_wdata, 64'h0);
    #2 rst = 1'b1;

    // Single read on the instruction port.
    req = 2'b01; wr = 2'b00; addr0 = 64'h100; mem_rdata = 64'hDEAD;
    step();
    check("rd_gnt", gnt, 2'b01);
    check("rd_mem_addr", mem_addr, 64'h100);
    check("rd_mem_wr", mem_wr, 1'b0);
    req = 2'b00;
    step();
    check("rd_gnt_pulse", gnt, 2'b00);
    check("rd_rvalid_early", rvalid, 2'b00);
    step();
    check("rd_rvalid", rvalid, 2'b01);
    check("rd_rdata", rdata, 64'hDEAD);
    step();
    check("rd_rvalid_pulse", rvalid, 2'b00);

    // Single write on the data port; rdata must keep the old read value.
    req = 2'b10; wr = 2'b10; addr1 = 64'h40; wdata1 = 64'h1234; mem_rdata = 64'hBEEF;
    step();
    check("wr_gnt", gnt, 2'b10);
    check("wr_mem_wr", mem_wr, 1'b1);
    check("wr_mem_wdata", mem_wdata, 64'h1234);
    check("wr_mem_addr", mem_addr, 64'h40);
    req = 2'b00; wr = 2'b00;
    step();
    check("wr_mem_wr_drop", mem_wr, 1'b0);
    check("wr_mem_wdata_hold", mem_wdata, 64'h1234);
    step();
    check("wr_rvalid", rvalid, 2'b10);
    check("wr_rdata_kept", rdata, 64'hDEAD);
    step();

    // Fresh reset, then both ports hold req for four back-to-back accesses.
    rst = 1'b0;
    step();
    #2 rst = 1'b1;
    req = 2'b11; wr = 2'b00; addr0 = 64'hA0; addr1 = 64'hB0; mem_rdata = 64'h11;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("tie_gnt%0d", i), gnt, tie_exp[i]);
      check($sformatf("tie_gnt_rv%0d", i), rvalid, 2'b00);
      step(); step();
      check($sformatf("tie_rvalid%0d", i), rvalid, tie_exp[i]);
    end
    req = 2'b00;
    step();
    check("tie_withdraw", gnt, 2'b00);

    // Request arriving in the rvalid cycle is granted on the very next edge.
    req = 2'b01;
    step();
    check("b2b_first_gnt", gnt, 2'b01);
    req = 2'b00;
    step(); step();
    check("b2b_first_rvalid", rvalid, 2'b01);
    req = 2'b11;
    step();
    check("b2b_second_gnt", gnt, 2'b10);
    check("b2b_no_overlap", rvalid, 2'b00);
    req = 2'b00;
    step(); step();
    check("b2b_second_rvalid", rvalid, 2'b10);
    step();

    // Instruction request pulsed only while WAIT is busy is never granted.
    req = 2'b10;
    step();
    check("wd_gnt_data", gnt, 2'b10);
    req = 2'b01;
    step();
    req = 2'b00;
    step();
    check("wd_rvalid", rvalid, 2'b10);
    step();
    check("wd_no_gnt_a", gnt, 2'b00);
    step();
    check("wd_no_gnt_b", gnt, 2'b00);

    // Reset in the first WAIT cycle of a write aborts it.
    req = 2'b01; wr = 2'b01; addr0 = 64'h80; wdata0 = 64'h55;
    step();
    check("ab_mem_wr", mem_wr, 1'b1);
    req = 2'b00; wr = 2'b00;
    #2 rst = 1'b0;
    #1;
    check("ab_mem_wr_async", mem_wr, 1'b0);
    check("ab_mem_addr", mem_addr, 64'h0);
    step();
    #2 rst = 1'b1;
    step();
    check("ab_no_rvalid_a", rvalid, 2'b00);
    step();
    check("ab_no_rvalid_b", rvalid, 2'b00);
    req = 2'b10; mem_rdata = 64'h77;
    step();
    check("ab_next_gnt", gnt, 2'b10);
    req = 2'b00;
    step(); step();
    check("ab_next_rvalid", rvalid, 2'b10);
    check("ab_next_rdata", rdata, 64'h77);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
